tlb_unit: RTL and testbench

- Translation and management responder for the CP0 TLB instructions.
- CP0 issues TLBP/TLBR/TLBWI/TLBWR requests; this block executes them against the entry array and returns the probe index or read entry, which CP0 loads into Index/EntryHi/EntryLo0/EntryLo1.
- Also serves the fetch and memory-stage address translations: physical address plus refill/invalid/modified flags, which CP0 consumes as i_tlb_exc/d_tlb_exc.
- Owns the Random register.

---
 rtl/mmu_pkg.sv | 51 +++++
 rtl/tlb_match.sv | 51 +++++
 rtl/tlb_unit.sv | 304 ++++++++++++++++++++++++++++++
 tb/tb_tlb_unit.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmu_pkg.sv
// mmu_pkg: shared types and constants for the TLB slice.
//   tlb_op_t     - CP0 management opcode (TLBP/TLBR/TLBWI/TLBWR)
//   tlb_entry_t  - one dual-page TLB entry
//   tlb_exc_t    - translation exception flags {refill, invalid, modified}
//   tlb_state_t  - management FSM states
//   pack_lo      - rebuilds a CP0 EntryLo word from stored fields
package mmu_pkg;

  typedef enum logic [1:0] {
    TLB_OP_TLBP  = 2'd0,
    TLB_OP_TLBR  = 2'd1,
    TLB_OP_TLBWI = 2'd2,
    TLB_OP_TLBWR = 2'd3
  } tlb_op_t;

  typedef struct packed {
    logic [18:0] vpn2;
    logic [7:0]  asid;
    logic        g;
    logic [19:0] pfn0;
    logic [2:0]  c0;
    logic        d0;
    logic        v0;
    logic [19:0] pfn1;
    logic [2:0]  c1;
    logic        d1;
    logic        v1;
  } tlb_entry_t;

  typedef struct packed {
    logic refill;
    logic invalid;
    logic modified;
  } tlb_exc_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PROBE = 2'd1,
    ST_RESP  = 2'd2
  } tlb_state_t;

  // kseg0/kseg1 select bits: addresses here bypass the TLB
  localparam logic [1:0] KSEG_UNMAPPED = 2'b10;

  // EntryLo layout: PFN[25:6], C[5:3], D[2], V[1], G[0]
  function automatic logic [31:0] pack_lo(input logic [19:0] pfn, input logic [2:0] c,
                                          input logic d, input logic v, input logic g);
    return {6'b000000, pfn, c, d, v, g};
  endfunction

endpackage

// File: rtl/tlb_match.sv
// tlb_match: combinational associative match of one VPN2/ASID against the
// whole entry array.
//   vpn2_tab/asid_tab/g_tab - per-entry tag fields
//   vpn2/asid               - key being looked up
//   hit                     - at least one entry matches
//   idx                     - lowest matching index (0 when no hit)
//   multi                   - more than one entry matches (TLB_MULTIHIT_EN builds
//                             only, otherwise tied 0)
module tlb_match #(
  parameter int NENTRY = 16,
  parameter int IDXW   = $clog2(NENTRY)
) (
  input  logic [NENTRY-1:0][18:0] vpn2_tab,
  input  logic [NENTRY-1:0][7:0]  asid_tab,
  input  logic [NENTRY-1:0]       g_tab,
  input  logic [18:0]             vpn2,
  input  logic [7:0]              asid,
  output logic                    hit,
  output logic [IDXW-1:0]         idx,
  output logic                    multi
);

  logic [NENTRY-1:0] match_s;

  // per-entry tag compare; global entries ignore the ASID
  always_comb begin
    match_s = '0;
    for (int i = 0; i < NENTRY; i++) begin
      match_s[i] = (vpn2_tab[i] == vpn2) && (g_tab[i] || (asid_tab[i] == asid));
    end
  end

  // priority encode: scanning downward leaves the lowest match in idx
  always_comb begin
    hit = |match_s;
    idx = '0;
    for (int i = NENTRY - 1; i >= 0; i--) begin
      idx = match_s[i] ? IDXW'(i) : idx;
    end
  end

`ifdef TLB_MULTIHIT_EN
  // clearing the lowest set bit leaves something only if two or more matched
  always_comb begin
    multi = ((match_s & (match_s - 1'b1)) != '0);
  end
`else
  assign multi = 1'b0;
`endif

endmodule

// File: rtl/tlb_unit.sv
// tlb_unit: TLB entry array, CP0 management responder and fetch/data
// address translation.
//   clk, resetn           - clock, async active-low reset
//   req_*                 - CP0 TLBP/TLBR/TLBWI/TLBWR request channel
//   resp_*                - TLBP/TLBR result, resp_valid pulses one cycle
//   wired, wired_we       - CP0 Wired value and write strobe
//   random                - Random register owned here
//   asid                  - current ASID for fetch/data lookups
//   i_*, d_*              - fetch and data translation ports, results
//                           registered one cycle after the request
//   multihit              - multiple-match pulse when built with
//                           TLB_MULTIHIT_EN, otherwise constant 0
module tlb_unit
  import mmu_pkg::*;
#(
  parameter int NENTRY = 16,
  parameter int IDXW   = $clog2(NENTRY)
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_op,
  input  logic [31:0]     req_index,
  input  logic [31:0]     req_entry_hi,
  input  logic [31:0]     req_entry_lo0,
  input  logic [31:0]     req_entry_lo1,
  output logic            resp_valid,
  output logic [31:0]     resp_index,
  output logic [31:0]     resp_entry_hi,
  output logic [31:0]     resp_entry_lo0,
  output logic [31:0]     resp_entry_lo1,
  input  logic [IDXW-1:0] wired,
  input  logic            wired_we,
  output logic [IDXW-1:0] random,
  input  logic [7:0]      asid,
  input  logic [31:0]     i_vaddr,
  input  logic            i_req,
  output logic [31:0]     i_paddr,
  output logic [2:0]      i_exc,
  input  logic [31:0]     d_vaddr,
  input  logic            d_req,
  input  logic            d_write,
  output logic [31:0]     d_paddr,
  output logic [2:0]      d_exc,
  output logic            multihit
);

  localparam logic [IDXW-1:0] RAND_TOP = IDXW'(NENTRY - 1);

  tlb_entry_t             entries_r [NENTRY];
  logic [NENTRY-1:0][18:0] vpn2_tab_s;
  logic [NENTRY-1:0][7:0]  asid_tab_s;
  logic [NENTRY-1:0]       g_tab_s;

  tlb_state_t      state_r, state_next_s;
  tlb_op_t         op_s;
  logic            handshake_s;
  logic            ready_r;
  logic [IDXW-1:0] random_r;
  logic [IDXW-1:0] wr_idx_s;
  tlb_entry_t      wr_entry_s;
  tlb_entry_t      rd_entry_s;

  logic [18:0]     probe_vpn2_r;
  logic [7:0]      probe_asid_r;

  logic            resp_valid_r;
  logic [31:0]     resp_index_r, resp_hi_r, resp_lo0_r, resp_lo1_r;

  logic            i_hit_s, d_hit_s, p_hit_s;
  logic [IDXW-1:0] i_idx_s, d_idx_s, p_idx_s;
  logic            i_multi_s, d_multi_s, p_multi_s;
  logic [34:0]     i_res_s, d_res_s;
  logic [31:0]     i_paddr_r, d_paddr_r;
  logic [2:0]      i_exc_r, d_exc_r;

  logic            unused_s;

  assign op_s        = tlb_op_t'(req_op);
  assign handshake_s = req_valid & ready_r;
  assign wr_idx_s    = (op_s == TLB_OP_TLBWR) ? random_r : req_index[IDXW-1:0];
  assign rd_entry_s  = entries_r[req_index[IDXW-1:0]];

  // fields outside the architected EntryHi/EntryLo/Index layout are ignored
  assign unused_s = ^{req_index[31:IDXW], req_entry_hi[12:8],
                      req_entry_lo0[31:26], req_entry_lo1[31:26]};

  // new entry image from the CP0 registers; an entry is global only if both halves say so
  always_comb begin
    wr_entry_s      = '0;
    wr_entry_s.vpn2 = req_entry_hi[31:13];
    wr_entry_s.asid = req_entry_hi[7:0];
    wr_entry_s.g    = req_entry_lo0[0] & req_entry_lo1[0];
    wr_entry_s.pfn0 = req_entry_lo0[25:6];
    wr_entry_s.c0   = req_entry_lo0[5:3];
    wr_entry_s.d0   = req_entry_lo0[2];
    wr_entry_s.v0   = req_entry_lo0[1];
    wr_entry_s.pfn1 = req_entry_lo1[25:6];
    wr_entry_s.c1   = req_entry_lo1[5:3];
    wr_entry_s.d1   = req_entry_lo1[2];
    wr_entry_s.v1   = req_entry_lo1[1];
  end

  // tag fields flattened for the match units
  always_comb begin
    vpn2_tab_s = '0;
    asid_tab_s = '0;
    g_tab_s    = '0;
    for (int i = 0; i < NENTRY; i++) begin
      vpn2_tab_s[i] = entries_r[i].vpn2;
      asid_tab_s[i] = entries_r[i].asid;
      g_tab_s[i]    = entries_r[i].g;
    end
  end

  tlb_match #(.NENTRY(NENTRY), .IDXW(IDXW)) u_match_i (
    .vpn2_tab(vpn2_tab_s), .asid_tab(asid_tab_s), .g_tab(g_tab_s),
    .vpn2(i_vaddr[31:13]), .asid(asid),
    .hit(i_hit_s), .idx(i_idx_s), .multi(i_multi_s)
  );

  tlb_match #(.NENTRY(NENTRY), .IDXW(IDXW)) u_match_d (
    .vpn2_tab(vpn2_tab_s), .asid_tab(asid_tab_s), .g_tab(g_tab_s),
    .vpn2(d_vaddr[31:13]), .asid(asid),
    .hit(d_hit_s), .idx(d_idx_s), .multi(d_multi_s)
  );

  tlb_match #(.NENTRY(NENTRY), .IDXW(IDXW)) u_match_p (
    .vpn2_tab(vpn2_tab_s), .asid_tab(asid_tab_s), .g_tab(g_tab_s),
    .vpn2(probe_vpn2_r), .asid(probe_asid_r),
    .hit(p_hit_s), .idx(p_idx_s), .multi(p_multi_s)
  );

  // translate one address against its selected entry; returns {paddr, exc}
  function automatic logic [34:0] xlate(input logic [31:0] vaddr, input logic hit,
                                        input tlb_entry_t e, input logic is_store);
    logic [19:0] pfn;
    logic        v;
    logic        d;
    logic [34:0] r;
    pfn = vaddr[12] ? e.pfn1 : e.pfn0;
    v   = vaddr[12] ? e.v1   : e.v0;
    d   = vaddr[12] ? e.d1   : e.d0;
    if (vaddr[31:30] == KSEG_UNMAPPED) begin
      r = {3'b000, vaddr[28:0], 3'b000};
    end else if (!hit) begin
      r = {32'h0000_0000, 3'b100};
    end else if (!v) begin
      r = {32'h0000_0000, 3'b010};
    end else if (is_store && !d) begin
      r = {32'h0000_0000, 3'b001};
    end else begin
      r = {pfn, vaddr[11:0], 3'b000};
    end
    return r;
  endfunction

  assign i_res_s = xlate(i_vaddr, i_hit_s, entries_r[i_idx_s], 1'b0);
  assign d_res_s = xlate(d_vaddr, d_hit_s, entries_r[d_idx_s], d_write);

  // entry array: cleared on reset, written by TLBWI/TLBWR at the handshake edge
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NENTRY; i++) begin
        entries_r[i] <= '0;
      end
    end else if (handshake_s && ((op_s == TLB_OP_TLBWI) || (op_s == TLB_OP_TLBWR))) begin
      entries_r[wr_idx_s] <= wr_entry_s;
    end
  end

  // Random: counts down to Wired then wraps; Wired/TLBWR writes restart it
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      random_r <= RAND_TOP;
    end else if (wired_we || (handshake_s && (op_s == TLB_OP_TLBWR))) begin
      random_r <= RAND_TOP;
    end else if ((wired >= RAND_TOP) || (random_r == wired)) begin
      random_r <= RAND_TOP;
    end else begin
      random_r <= random_r - 1'b1;
    end
  end

  // management FSM state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // management FSM next state: writes complete in IDLE, reads/probes respond
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (handshake_s && (op_s == TLB_OP_TLBP)) begin
          state_next_s = ST_PROBE;
        end else if (handshake_s && (op_s == TLB_OP_TLBR)) begin
          state_next_s = ST_RESP;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_PROBE: state_next_s = ST_RESP;
      ST_RESP:  state_next_s = ST_IDLE;
      default:  state_next_s = ST_IDLE;
    endcase
  end

  // probe key captured at the TLBP handshake
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      probe_vpn2_r <= '0;
      probe_asid_r <= '0;
    end else if (handshake_s && (op_s == TLB_OP_TLBP)) begin
      probe_vpn2_r <= req_entry_hi[31:13];
      probe_asid_r <= req_entry_hi[7:0];
    end
  end

  // response registers; resp_valid is high exactly while the FSM sits in RESP
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ready_r      <= 1'b1;
      resp_valid_r <= 1'b0;
      resp_index_r <= '0;
      resp_hi_r    <= '0;
      resp_lo0_r   <= '0;
      resp_lo1_r   <= '0;
    end else begin
      ready_r      <= (state_next_s == ST_IDLE);
      resp_valid_r <= (state_next_s == ST_RESP);
      if (state_r == ST_PROBE) begin
        resp_index_r <= p_hit_s ? {{(32-IDXW){1'b0}}, p_idx_s} : 32'h8000_0000;
      end
      if ((state_r == ST_IDLE) && handshake_s && (op_s == TLB_OP_TLBR)) begin
        resp_hi_r  <= {rd_entry_s.vpn2, 5'b00000, rd_entry_s.asid};
        resp_lo0_r <= pack_lo(rd_entry_s.pfn0, rd_entry_s.c0, rd_entry_s.d0,
                              rd_entry_s.v0, rd_entry_s.g);
        resp_lo1_r <= pack_lo(rd_entry_s.pfn1, rd_entry_s.c1, rd_entry_s.d1,
                              rd_entry_s.v1, rd_entry_s.g);
      end
    end
  end

  // fetch translation result, held while i_req is low
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      i_paddr_r <= '0;
      i_exc_r   <= '0;
    end else if (i_req) begin
      i_paddr_r <= i_res_s[34:3];
      i_exc_r   <= i_res_s[2:0];
    end
  end

  // data translation result, held while d_req is low
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      d_paddr_r <= '0;
      d_exc_r   <= '0;
    end else if (d_req) begin
      d_paddr_r <= d_res_s[34:3];
      d_exc_r   <= d_res_s[2:0];
    end
  end

`ifdef TLB_MULTIHIT_EN
  logic multihit_r;

  // multihit pulse lines up with the registered lookup result or with resp_valid
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      multihit_r <= 1'b0;
    end else begin
      multihit_r <= (i_req && (i_vaddr[31:30] != KSEG_UNMAPPED) && i_multi_s) ||
                    (d_req && (d_vaddr[31:30] != KSEG_UNMAPPED) && d_multi_s) ||
                    ((state_r == ST_PROBE) && p_multi_s);
    end
  end
  assign multihit = multihit_r;
`else
  logic multi_unused_s;
  assign multi_unused_s = i_multi_s ^ d_multi_s ^ p_multi_s;
  assign multihit = 1'b0;
`endif

  assign req_ready      = ready_r;
  assign random         = random_r;
  assign resp_valid     = resp_valid_r;
  assign resp_index     = resp_index_r;
  assign resp_entry_hi  = resp_hi_r;
  assign resp_entry_lo0 = resp_lo0_r;
  assign resp_entry_lo1 = resp_lo1_r;
  assign i_paddr        = i_paddr_r;
  assign i_exc          = {i_exc_r[2:1], 1'b0};
  assign d_paddr        = d_paddr_r;
  assign d_exc          = d_exc_r;

endmodule

// File: tb/tb_tlb_unit.sv
// tb_tlb_unit: directed, table-driven bench for tlb_unit (NENTRY=16).
// Works in both builds; TLB_MULTIHIT_EN changes only the expected multihit.
module tb_tlb_unit;

  localparam int NENTRY = 16;
  localparam int IDXW   = 4;
`ifdef TLB_MULTIHIT_EN
  localparam logic MH_EXP = 1'b1;
`else
  localparam logic MH_EXP = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            resetn;
  logic            req_valid;
  logic            req_ready;
  logic [1:0]      req_op;
  logic [31:0]     req_index, req_entry_hi, req_entry_lo0, req_entry_lo1;
  logic            resp_valid;
  logic [31:0]     resp_index, resp_entry_hi, resp_entry_lo0, resp_entry_lo1;
  logic [IDXW-1:0] wired;
  logic            wired_we;
  logic [IDXW-1:0] random;
  logic [7:0]      asid;
  logic [31:0]     i_vaddr, i_paddr, d_vaddr, d_paddr;
  logic            i_req, d_req, d_write;
  logic [2:0]      i_exc, d_exc;
  logic            multihit;

  int n_vec  = 0;
  int n_miss = 0;

  tlb_unit #(.NENTRY(NENTRY), .IDXW(IDXW)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_index(req_index), .req_entry_hi(req_entry_hi),
    .req_entry_lo0(req_entry_lo0), .req_entry_lo1(req_entry_lo1),
    .resp_valid(resp_valid), .resp_index(resp_index),
    .resp_entry_hi(resp_entry_hi), .resp_entry_lo0(resp_entry_lo0),
    .resp_entry_lo1(resp_entry_lo1),
    .wired(wired), .wired_we(wired_we), .random(random), .asid(asid),
    .i_vaddr(i_vaddr), .i_req(i_req), .i_paddr(i_paddr), .i_exc(i_exc),
    .d_vaddr(d_vaddr), .d_req(d_req), .d_write(d_write),
    .d_paddr(d_paddr), .d_exc(d_exc), .multihit(multihit)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] vaddr;
    logic [7:0]  asid;
    logic        wr;
    logic [31:0] paddr;
    logic [2:0]  exc;
  } lk_vec_t;

  lk_vec_t tab_empty [3];
  lk_vec_t tab_mapped [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // advance one clock; inputs change and outputs are sampled 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic d_lookup(input lk_vec_t v);
    d_vaddr = v.vaddr;
    asid    = v.asid;
    d_write = v.wr;
    d_req   = 1'b1;
    step();
    d_req   = 1'b0;
    chk({v.name, "_paddr"}, d_paddr, v.paddr);
    chk({v.name, "_exc"}, {29'h0, d_exc}, {29'h0, v.exc});
  endtask

  task automatic mgmt_write(input logic [1:0] op, input logic [31:0] idx, input logic [31:0] hi,
                            input logic [31:0] lo0, input logic [31:0] lo1);
    req_valid     = 1'b1;
    req_op        = op;
    req_index     = idx;
    req_entry_hi  = hi;
    req_entry_lo0 = lo0;
    req_entry_lo1 = lo1;
    step();
    req_valid     = 1'b0;
  endtask

  task automatic probe(input string name, input logic [31:0] hi, input logic [31:0] exp_idx,
                       input logic exp_mh);
    req_valid    = 1'b1;
    req_op       = 2'd0;
    req_entry_hi = hi;
    step();
    req_valid    = 1'b0;
    chk({name, "_rdy_probe"}, {31'h0, req_ready}, 32'h0);
    chk({name, "_vld_probe"}, {31'h0, resp_valid}, 32'h0);
    step();
    chk({name, "_rdy_resp"}, {31'h0, req_ready}, 32'h0);
    chk({name, "_vld_resp"}, {31'h0, resp_valid}, 32'h1);
    chk({name, "_index"}, resp_index, exp_idx);
    chk({name, "_multihit"}, {31'h0, multihit}, {31'h0, exp_mh});
    step();
    chk({name, "_rdy_idle"}, {31'h0, req_ready}, 32'h1);
    chk({name, "_vld_idle"}, {31'h0, resp_valid}, 32'h0);
  endtask

  task automatic read_entry(input string name, input logic [31:0] idx, input logic [31:0] hi,
                            input logic [31:0] lo0, input logic [31:0] lo1);
    req_valid = 1'b1;
    req_op    = 2'd1;
    req_index = idx;
    step();
    req_valid = 1'b0;
    chk({name, "_vld"}, {31'h0, resp_valid}, 32'h1);
    chk({name, "_rdy"}, {31'h0, req_ready}, 32'h0);
    chk({name, "_hi"}, resp_entry_hi, hi);
    chk({name, "_lo0"}, resp_entry_lo0, lo0);
    chk({name, "_lo1"}, resp_entry_lo1, lo1);
    step();
    chk({name, "_vld_end"}, {31'h0, resp_valid}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [IDXW-1:0] exp_rand;
    logic [31:0]     held;

    tab_empty[0] = '{"empty_refill", 32'h0040_0000, 8'h05, 1'b0, 32'h0000_0000, 3'b100};
    tab_empty[1] = '{"kseg0",        32'h8000_1234, 8'h05, 1'b0, 32'h0000_1234, 3'b000};
    tab_empty[2] = '{"kseg1_store",  32'hA000_5678, 8'h05, 1'b1, 32'h0000_5678, 3'b000};

    tab_mapped[0] = '{"hit_even",    32'h0040_0ABC, 8'h05, 1'b0, 32'h0012_3ABC, 3'b000};
    tab_mapped[1] = '{"odd_invalid", 32'h0040_1000, 8'h05, 1'b0, 32'h0000_0000, 3'b010};
    tab_mapped[2] = '{"asid_refill", 32'h0040_0ABC, 8'h06, 1'b0, 32'h0000_0000, 3'b100};
    tab_mapped[3] = '{"store_mod",   32'h0080_0010, 8'h09, 1'b1, 32'h0000_0000, 3'b001};
    tab_mapped[4] = '{"load_nomod",  32'h0080_0010, 8'h09, 1'b0, 32'h000A_B010, 3'b000};
    tab_mapped[5] = '{"store_dirty", 32'h0080_1020, 8'h33, 1'b1, 32'h000C_D020, 3'b000};
    tab_mapped[6] = '{"store_hit",   32'h0040_0ABC, 8'h05, 1'b1, 32'h0012_3ABC, 3'b000};

    resetn = 1'b0; req_valid = 1'b0; req_op = 2'd0; req_index = '0;
    req_entry_hi = '0; req_entry_lo0 = '0; req_entry_lo1 = '0;
    wired = '0; wired_we = 1'b0; asid = '0;
    i_vaddr = '0; i_req = 1'b0; d_vaddr = '0; d_req = 1'b0; d_write = 1'b0;

    repeat (3) step();
    chk("rst_random", {28'h0, random}, 32'd15);
    chk("rst_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rst_d_paddr", d_paddr, 32'h0);
    chk("rst_d_exc", {29'h0, d_exc}, 32'h0);
    chk("rst_i_exc", {29'h0, i_exc}, 32'h0);
    resetn = 1'b1;
    step();

    for (int k = 0; k < 3; k++) d_lookup(tab_empty[k]);

    // idx3: VPN2 0x200 ASID 5, even PFN 0x123 V D, odd PFN 0x456 D only
    mgmt_write(2'd2, 32'd3, 32'h0040_0005, 32'h0000_48C6, 32'h0001_1584);
    // idx5: global, even PFN 0xAB clean, odd PFN 0xCD dirty
    mgmt_write(2'd2, 32'd5, 32'h0080_0005, 32'h0000_2AC3, 32'h0000_3347);
    for (int k = 0; k < 7; k++) d_lookup(tab_mapped[k]);

    // outputs hold while d_req is low
    held      = d_paddr;
    d_vaddr   = 32'h8000_0000;
    step();
    chk("hold_paddr", d_paddr, held);

    // fetch port: store-style protection never applies; invalid page still flagged
    i_vaddr = 32'h0080_0010; asid = 8'h09; i_req = 1'b1;
    step();
    chk("i_hit_paddr", i_paddr, 32'h000A_B010);
    chk("i_hit_exc", {29'h0, i_exc}, 32'h0);
    i_vaddr = 32'h0040_1000; asid = 8'h05;
    step();
    i_req = 1'b0;
    chk("i_invalid_exc", {29'h0, i_exc}, {29'h0, 3'b010});

    // lookup in the same cycle as a write sees the old array
    d_vaddr = 32'h0100_0000; asid = 8'h05; d_write = 1'b0; d_req = 1'b1;
    mgmt_write(2'd2, 32'd7, 32'h0100_0005, 32'h0001_DDC6, 32'h0000_0000);
    chk("prewrite_exc", {29'h0, d_exc}, {29'h0, 3'b100});
    step();
    d_req = 1'b0;
    chk("postwrite_paddr", d_paddr, 32'h0077_7000);
    chk("postwrite_exc", {29'h0, d_exc}, 32'h0);

    probe("tlbp_hit3", 32'h0040_0005, 32'd3, 1'b0);
    probe("tlbp_global5", 32'h0080_00FF, 32'd5, 1'b0);
    probe("tlbp_miss", 32'h0040_0006, 32'h8000_0000, 1'b0);
    // TLBP captured the cycle after a TLBWI sees the new entry
    mgmt_write(2'd2, 32'd9, 32'h0200_0007, 32'h0000_0006, 32'h0000_0006);
    probe("tlbp_after_wi", 32'h0200_0007, 32'd9, 1'b0);

    read_entry("tlbr3", 32'd3, 32'h0040_0005, 32'h0000_48C6, 32'h0001_1584);
    read_entry("tlbr5_g", 32'd5, 32'h0080_0005, 32'h0000_2AC3, 32'h0000_3347);
    mgmt_write(2'd2, 32'd10, 32'h0300_0001, 32'h0000_0043, 32'h0000_0082);
    read_entry("tlbr10_gmix", 32'd10, 32'h0300_0001, 32'h0000_0042, 32'h0000_0082);

    // Random with wired=4
    wired = 4'd4; wired_we = 1'b1;
    step();
    wired_we = 1'b0;
    exp_rand = 4'd15;
    chk("rand_wired_we", {28'h0, random}, 32'd15);
    for (int k = 0; k < 20; k++) begin
      step();
      exp_rand = (exp_rand == wired) ? 4'd15 : exp_rand - 4'd1;
      chk($sformatf("rand_seq%0d", k), {28'h0, random}, {28'h0, exp_rand});
    end
    // TLBWR lands at the Random value sampled on its handshake edge
    mgmt_write(2'd3, 32'd0, 32'h0400_0003, 32'h0000_1006, 32'h0000_2046);
    chk("rand_after_wr", {28'h0, random}, 32'd15);
    read_entry("tlbr_wr", {28'h0, exp_rand}, 32'h0400_0003, 32'h0000_1006, 32'h0000_2046);

    wired = 4'd15; wired_we = 1'b1;
    step();
    wired_we = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("rand_hold%0d", k), {28'h0, random}, 32'd15);
    end
    wired = 4'd0; wired_we = 1'b1;
    step();
    wired_we = 1'b0;

    // two global entries with the same VPN2: lowest index wins
    mgmt_write(2'd2, 32'd13, 32'h0600_0000, 32'h0000_0443, 32'h0000_0001);
    mgmt_write(2'd2, 32'd14, 32'h0600_0000, 32'h0000_0883, 32'h0000_0001);
    d_vaddr = 32'h0600_0123; asid = 8'h44; d_write = 1'b0; d_req = 1'b1;
    step();
    d_req = 1'b0;
    chk("mh_paddr", d_paddr, 32'h0001_1123);
    chk("mh_pulse", {31'h0, multihit}, {31'h0, MH_EXP});
    step();
    chk("mh_clear", {31'h0, multihit}, 32'h0);
    probe("tlbp_multi", 32'h0600_0000, 32'd13, MH_EXP);

    // reset while PROBE is pending: no response may appear
    req_valid = 1'b1; req_op = 2'd0; req_entry_hi = 32'h0040_0005;
    step();
    req_valid = 1'b0;
    resetn = 1'b0;
    #3;
    resetn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("abort_vld%0d", k), {31'h0, resp_valid}, 32'h0);
    end
    chk("abort_ready", {31'h0, req_ready}, 32'h1);
    d_lookup('{"cleared_refill", 32'h0040_0ABC, 8'h05, 1'b0, 32'h0000_0000, 3'b100});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
